// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, datapath width, result bundle and
// the result-buffer state type used by the shared adder front end.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic              ovf;
    } alu_res_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the ALU issue logic and the shared adder.
interface adder_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_op;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [DATA_W-1:0]      rsp_sum;
    logic                   rsp_cout;
    logic                   rsp_ovf;
    logic [31:0]            ops_done;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, ops_done
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, ops_done
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr, modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    logic        found;
    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!found && valid[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
                if (enable) grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/thirtyTwoBitAdder.sv
// 32-bit adder built from eight 4-bit carry-lookahead blocks, block carries rippled.
module thirtyTwoBitAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [8:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < 8; g++) begin : g_cla
        logic [3:0] p;
        logic [3:0] gn;
        logic [4:0] cc;

        assign p     = a[4*g +: 4] ^ b[4*g +: 4];
        assign gn    = a[4*g +: 4] & b[4*g +: 4];
        assign cc[0] = c[g];
        assign cc[1] = gn[0] | (p[0] & cc[0]);
        assign cc[2] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0])
                     | (p[2] & p[1] & p[0] & cc[0]);
        assign cc[4] = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1])
                     | (p[3] & p[2] & p[1] & gn[0])
                     | (p[3] & p[2] & p[1] & p[0] & cc[0]);

        assign sum[4*g +: 4] = p ^ cc[3:0];
        assign c[g+1]        = cc[4];
    end

    assign cout = c[8];
endmodule

// File: rtl/adder_arbiter.sv
// Shares one 32-bit CLA among NREQ add/sub requesters, round-robin, with a
// one-entry registered result buffer and an accepted-result counter.
module adder_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input logic            clk,
    input logic            rst,
    adder_arbiter_if.slave bus
);
    if (NREQ < 2 || NREQ > 8 || NREQ > (1 << IDW)) begin : g_bad_param
        $error("adder_arbiter: NREQ must be 2..8 and fit in IDW bits");
    end

    buf_state_t        state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    id_q;
    alu_res_t          res;
    logic [31:0]       ops;

    logic              slot_free;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    gidx;
    logic              accept;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              op_sel;
    logic [DATA_W-1:0] b_mux;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              add_ovf;

    assign slot_free = (state == ST_EMPTY) || bus.rsp_ready;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid  (bus.req_valid),
        .ptr    (ptr),
        .enable (slot_free && !rst),
        .grant  (grant),
        .idx    (gidx)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;

    // Operand select; grant is one-hot so an AND-OR mux suffices.
    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = OP_ADD;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel  = bus.req_a[i*DATA_W +: DATA_W];
                b_sel  = bus.req_b[i*DATA_W +: DATA_W];
                op_sel = bus.req_op[i];
            end
        end
    end

    assign b_mux = (op_sel == OP_SUB) ? ~b_sel : b_sel;

    thirtyTwoBitAdder u_add (
        .a    (a_sel),
        .b    (b_mux),
        .cin  (op_sel == OP_SUB),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign add_ovf = (a_sel[DATA_W-1] == b_mux[DATA_W-1]) && (add_sum[DATA_W-1] != a_sel[DATA_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            ptr   <= '0;
            id_q  <= '0;
            res   <= '0;
            ops   <= '0;
        end else begin
            if (state == ST_FULL && bus.rsp_ready) ops <= ops + 32'd1;
            if (accept) begin
                res   <= '{sum: add_sum, cout: add_cout, ovf: add_ovf};
                id_q  <= gidx;
                ptr   <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
            end
            case (state)
                ST_EMPTY: if (accept) state <= ST_FULL;
                ST_FULL:  if (bus.rsp_ready && !accept) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.rsp_valid = (state == ST_FULL);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = res.sum;
    assign bus.rsp_cout  = res.cout;
    assign bus.rsp_ovf   = res.ovf;
    assign bus.ops_done  = ops;

    // A pending request must hold its op, operands and valid until accepted.
    for (genvar i = 0; i < NREQ; i++) begin : g_req_chk
        a_req_stable: assert property (@(posedge clk) disable iff (rst)
            (bus.req_valid[i] && !bus.req_ready[i]) |=>
                (bus.req_valid[i] && $stable(bus.req_op[i])
                 && $stable(bus.req_a[i*DATA_W +: DATA_W])
                 && $stable(bus.req_b[i*DATA_W +: DATA_W])));
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with NREQ=4: reset, add/sub flags,
// round-robin order, backpressure and counter wrap.
module tb_adder_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    adder_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]       = 1'b1;
        bus.req_op[i]          = op;
        bus.req_a[i*32 +: 32]  = a;
        bus.req_b[i*32 +: 32]  = b;
    endtask

    task automatic chk_rsp(input string tag, input logic [2:0] id, input logic [31:0] sum,
                           input logic cout, input logic ovf);
        chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'(1));
        chk({tag, "_id"},    64'(bus.rsp_id),    64'(id));
        chk({tag, "_sum"},   64'(bus.rsp_sum),   64'(sum));
        chk({tag, "_cout"},  64'(bus.rsp_cout),  64'(cout));
        chk({tag, "_ovf"},   64'(bus.rsp_ovf),   64'(ovf));
    endtask

    initial begin
        logic [31:0] ops_before;
        logic [2:0]  exp_id;
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_ops",   64'(bus.ops_done),  64'(0));

        // Leave a result pending, then reset with rsp_ready high.
        set_req(0, 1'b0, 32'd1, 32'd2);
        tick();
        chk_rsp("pend", 3'd0, 32'd3, 1'b0, 1'b0);
        set_req(0, 1'b0, 32'd3, 32'd4);
        rst           = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        tick();
        chk("rst_mid_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_mid_ready", 64'(bus.req_ready), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("post_valid", 64'(bus.rsp_valid), 64'(0));
        chk("post_id",    64'(bus.rsp_id),    64'(0));
        chk("post_sum",   64'(bus.rsp_sum),   64'(0));
        chk("post_cout",  64'(bus.rsp_cout),  64'(0));
        chk("post_ovf",   64'(bus.rsp_ovf),   64'(0));
        chk("post_ops",   64'(bus.ops_done),  64'(0));
        chk("post_ready", 64'(bus.req_ready), 64'(1));
        tick();
        chk_rsp("held", 3'd0, 32'd7, 1'b0, 1'b0);
        chk("held_ops", 64'(bus.ops_done), 64'(0));

        // Add cases on requester 0, back-to-back.
        set_req(0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk_rsp("add_wrap", 3'd0, 32'h0, 1'b1, 1'b0);
        chk("add_ops", 64'(bus.ops_done), 64'(1));
        set_req(0, 1'b0, 32'h7FFF_FFFF, 32'd1);
        tick();
        chk_rsp("add_ovf", 3'd0, 32'h8000_0000, 1'b0, 1'b1);
        bus.req_valid[0] = 1'b0;

        // Sub cases on requester 1.
        set_req(1, 1'b1, 32'd5, 32'd7);
        tick();
        chk_rsp("sub_borrow", 3'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        set_req(1, 1'b1, 32'h8000_0000, 32'd1);
        tick();
        chk_rsp("sub_ovf", 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        bus.req_valid[1] = 1'b0;
        tick();
        chk("drain_valid", 64'(bus.rsp_valid), 64'(0));
        chk("drain_ops",   64'(bus.ops_done),  64'(5));

        // Round-robin from a fresh pointer; requesters drop out after their grant.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'(i * 16), 32'd1);
        for (int k = 0; k < 15; k++) begin
            exp_id = (k < 12) ? 3'(k % 4) : 3'd2;
            #1;
            chk($sformatf("rr_ready%0d", k), 64'(bus.req_ready), 64'(4'b1 << exp_id));
            tick();
            chk($sformatf("rr_id%0d", k),  64'(bus.rsp_id),  64'(exp_id));
            chk($sformatf("rr_sum%0d", k), 64'(bus.rsp_sum), 64'(32'(exp_id) * 32'd16 + 32'd1));
            if (k >= 8 && exp_id != 3'd2) bus.req_valid[exp_id] = 1'b0;
        end
        bus.req_valid = '0;
        tick();
        chk("rr_drain", 64'(bus.rsp_valid), 64'(0));

        // Backpressure: one accept, then four stalled cycles with outputs held.
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b0, 32'h100, 32'h23);
        #1;
        chk("bp_ready0", 64'(bus.req_ready), 64'(1));
        tick();
        set_req(0, 1'b0, 32'h200, 32'h5);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_stall_ready%0d", k), 64'(bus.req_ready), 64'(0));
            chk_rsp($sformatf("bp_stall%0d", k), 3'd0, 32'h123, 1'b0, 1'b0);
            tick();
        end
        ops_before    = bus.ops_done;
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.req_ready), 64'(1));
        tick();
        chk_rsp("bp_swap", 3'd0, 32'h205, 1'b0, 1'b0);
        chk("bp_ops", 64'(bus.ops_done), 64'(ops_before + 32'd1));
        bus.req_valid = '0;
        tick();
        chk("bp_drain", 64'(bus.rsp_valid), 64'(0));
        chk("bp_ops2", 64'(bus.ops_done), 64'(ops_before + 32'd2));

        // Counter wrap via preload of the internal count.
        force dut.ops = 32'hFFFF_FFFF;
        #1;
        release dut.ops;
        set_req(2, 1'b0, 32'd10, 32'd20);
        tick();
        chk("wrap_pre", 64'(bus.ops_done), 64'(32'hFFFF_FFFF));
        chk_rsp("wrap_rsp", 3'd2, 32'd30, 1'b0, 1'b0);
        bus.req_valid = '0;
        tick();
        chk("wrap_ops", 64'(bus.ops_done), 64'(0));
        chk("wrap_valid", 64'(bus.rsp_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit carry-lookahead adder (existing thirtyTwoBitAdder, 8×4-bit CLA) among NREQ requesters. Each requester issues add/sub operations.
- Selects one requester per cycle by round-robin. Drives the adder, including B inversion and Cin for subtract.
- Registers the result with flags into a one-entry output buffer under valid/ready flow control.
- Sits between ALU issue logic and the AddSub datapath.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- IDW, 3, width of requester ID field; must satisfy 2^IDW ≥ NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_op  in  NREQ  per-requester op: 0 = add, 1 = sub (A−B).
- req_a  in  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  NREQ*32  operand B; same packing as req_a.
- rsp_valid  out  1  result buffer holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that produced the result.
- rsp_sum  out  32  sum or difference.
- rsp_cout  out  1  carry-out; for sub this is the not-borrow bit.
- rsp_ovf  out  1  signed overflow.
- ops_done  out  32  count of results accepted by the consumer; wraps modulo 2^32.

Behaviour:
- Reset: synchronous, rst=1 sampled at a rising edge.
  - Clears rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, ops_done and the priority pointer to 0.
  - req_ready is 0 while rst=1.
  - A result pending at reset is discarded and not counted.
- slot_free = !rsp_valid || rsp_ready.
- Grant selection (combinational):
  - g = first i with req_valid[i]=1, scanning ptr, ptr+1, … modulo NREQ.
  - req_ready[g] = slot_free; all other req_ready bits are 0.
  - No grant when no req_valid bit is set.
  - req_ready does not depend on req_op, req_a or req_b.
- Datapath (combinational, same cycle as grant):
  - Adder A = req_a[g].
  - Adder B = req_op[g] ? ~req_b[g] : req_b[g].
  - Adder Cin = req_op[g].
- Accept occurs when req_valid[g] && req_ready[g]. On the accepting edge:
  - rsp_sum ← S; rsp_cout ← Cout; rsp_id ← g; rsp_valid ← 1.
  - rsp_ovf ← (A[31]==Bmux[31]) && (S[31]!=A[31]).
  - ptr ← (g+1) mod NREQ.
- Latency and throughput:
  - Result is visible at rsp_* one cycle after accept.
  - Back-to-back throughput is one op per cycle while rsp_ready=1.
- Drain with no new accept: when rsp_valid && rsp_ready, rsp_valid ← 0.
- Simultaneous drain and accept: rsp_valid stays 1 and the buffer loads the new result.
- Stall: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable and all req_ready bits are 0.
- Pointer: changes only on accept. Idle cycles and stall cycles leave it unchanged.
- Counter: ops_done increments by 1 on each rsp_valid && rsp_ready edge; wraps 0xFFFFFFFF → 0.
- Fairness: any requester holding req_valid is granted within NREQ accepts.
- Requester protocol (checked by assertion only): once req_valid is asserted, operands, op and valid stay stable until accepted.
- Invalid NREQ > 2^IDW is a parameter error, checked at elaboration.
- Implementation sketch:
  - Two logical states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without accept.
  - FULL → FULL on stall, or on drain with accept.

Decomposition:
- Shared package alu_pkg holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1.
  - DATA_W=32.
  - Result flag bundle typedef {sum, cout, ovf}.
- Natural sub-module: rr_arbiter (NREQ, IDW).
  - Inputs: valid vector, ptr, enable.
  - Outputs: one-hot grant and encoded index.
- thirtyTwoBitAdder is instantiated unchanged.

Test Plan:
1. Reset/idle:
   - Stimulus: assert rst for 2 cycles mid-stream with rsp_valid=1.
   - Required: all outputs 0 the next cycle, and ops_done unchanged by the dropped result (=0).
2. Add:
   - Stimulus: req0 add, A=0xFFFFFFFF, B=1, rsp_ready=1.
   - Required: next cycle rsp_sum=0, cout=1, ovf=0, id=0.
   - Stimulus: A=0x7FFFFFFF, B=1.
   - Required: sum=0x80000000, ovf=1, cout=0.
3. Sub:
   - Stimulus: req1 sub, A=5, B=7.
   - Required: sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
   - Stimulus: A=0x80000000, B=1.
   - Required: sum=0x7FFFFFFF, ovf=1, cout=1.
4. Round-robin:
   - Stimulus: NREQ=4, all req_valid held high, rsp_ready=1 for 8 cycles.
   - Required: rsp_id sequence 0,1,2,3,0,1,2,3.
   - Stimulus: then only req2 valid.
   - Required: granted every cycle.
5. Backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles with req0 valid.
   - Required: exactly one accept, rsp_* stable, req_ready=0 for 4 cycles.
   - Stimulus: rsp_ready=1.
   - Required: drain and new accept in the same cycle; ops_done increments by 1.
6. Counter wrap:
   - Stimulus: force ops_done to 0xFFFFFFFF via 2^32-accurate model/preload hook, then complete one op.
   - Required: ops_done=0.
